// File: rtl/storage_compare_monitor.sv
// storage_compare_monitor
// Synchronises the latch / posedge-FF / negedge-FF outputs (qa, qb, qc) into
// clk, then over a software-started window of N cycles counts per-pair
// disagreements and records the first window index with any disagreement.
// Results are held with done until the next start.
// Optional build macro STORAGE_CMP_TOGGLE_CNT_EN adds per-input toggle counters
// (tog_a, tog_b, tog_c).
module storage_compare_monitor #(
  parameter int CNT_W       = 16,
  parameter int WIN_W       = 16,
  parameter int SYNC_STAGES = 2    // legal range 2..4
) (
  input  logic             clk,
  input  logic             rst_n,
  input  logic             qa,
  input  logic             qb,
  input  logic             qc,
  input  logic             start,
  input  logic [WIN_W-1:0] window_len,
  output logic             busy,
  output logic             done,
  output logic [CNT_W-1:0] cnt_ab,
  output logic [CNT_W-1:0] cnt_bc,
  output logic [CNT_W-1:0] cnt_ac,
  output logic [WIN_W-1:0] first_idx,
  output logic             first_vld
`ifdef STORAGE_CMP_TOGGLE_CNT_EN
  ,
  output logic [CNT_W-1:0] tog_a,
  output logic [CNT_W-1:0] tog_b,
  output logic [CNT_W-1:0] tog_c
`endif
);

  typedef enum logic [1:0] {
    S_IDLE    = 2'd0,
    S_ARM     = 2'd1,
    S_MEASURE = 2'd2,
    S_DONE    = 2'd3
  } state_t;

  localparam logic [1:0]       ARM_LAST = 2'(SYNC_STAGES - 1);
  localparam logic [WIN_W-1:0] WIN_ONE  = WIN_W'(1);

  state_t                 state, state_nxt;
  logic                   accept;
  logic [SYNC_STAGES-1:0] sync_a, sync_b, sync_c;
  logic                   sa, sb, sc;
  logic [1:0]             arm_cnt;
  logic [WIN_W-1:0]       win_len_q;
  logic [WIN_W-1:0]       idx;
  logic                   last_sample;
  logic                   diff_ab, diff_bc, diff_ac;

  // Saturating increment: holds at all-ones instead of wrapping.
  function automatic logic [CNT_W-1:0] sat_inc(input logic [CNT_W-1:0] v);
    return (&v) ? v : v + 1'b1;
  endfunction

  assign sa = sync_a[SYNC_STAGES-1];
  assign sb = sync_b[SYNC_STAGES-1];
  assign sc = sync_c[SYNC_STAGES-1];

  assign diff_ab = sa ^ sb;
  assign diff_bc = sb ^ sc;
  assign diff_ac = sa ^ sc;

  // The window index never exceeds N-1, so a full-range N cannot overflow it.
  assign last_sample = (idx == win_len_q - WIN_ONE);

  // Input synchronisers run in every state, independent of the FSM.
  always_ff @(posedge clk or negedge rst_n) begin
    // NOTE: every flop here is reset, including the synchroniser chains, so
    // the first post-reset samples are deterministic rather than X.
    if (!rst_n) begin
      sync_a <= '0;
      sync_b <= '0;
      sync_c <= '0;
    end else begin
      // NOTE: non-blocking assignments make each stage take the previous
      // stage's old value, which is what forms a shift chain.
      sync_a <= {sync_a[SYNC_STAGES-2:0], qa};
      sync_b <= {sync_b[SYNC_STAGES-2:0], qb};
      sync_c <= {sync_c[SYNC_STAGES-2:0], qc};
    end
  end

  // Next-state logic; start is only honoured from IDLE or DONE.
  always_comb begin
    // NOTE: defaults first, so no path through the case leaves a variable
    // unassigned and no latch is inferred.
    state_nxt = state;
    accept    = 1'b0;
    case (state)
      S_IDLE, S_DONE: begin
        if (start) begin
          state_nxt = S_ARM;
          accept    = 1'b1;
        end
      end
      S_ARM: begin
        if (arm_cnt == ARM_LAST) begin
          state_nxt = (win_len_q == '0) ? S_DONE : S_MEASURE;
        end
      end
      S_MEASURE: begin
        if (last_sample) state_nxt = S_DONE;
      end
      default: state_nxt = S_IDLE;
    endcase
  end

  // State register with registered busy/done decoded from the next state.
  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      state <= S_IDLE;
      busy  <= 1'b0;
      done  <= 1'b0;
    end else begin
      state <= state_nxt;
      busy  <= (state_nxt == S_ARM) || (state_nxt == S_MEASURE);
      done  <= (state_nxt == S_DONE);
    end
  end

  // Window bookkeeping and mismatch counters; cleared on every accepted start.
  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      win_len_q <= '0;
      arm_cnt   <= '0;
      idx       <= '0;
      cnt_ab    <= '0;
      cnt_bc    <= '0;
      cnt_ac    <= '0;
      first_idx <= '0;
      first_vld <= 1'b0;
    end else if (accept) begin
      win_len_q <= window_len;
      arm_cnt   <= '0;
      idx       <= '0;
      cnt_ab    <= '0;
      cnt_bc    <= '0;
      cnt_ac    <= '0;
      first_idx <= '0;
      first_vld <= 1'b0;
    end else begin
      if (state == S_ARM) arm_cnt <= arm_cnt + 1'b1;
      if (state == S_MEASURE) begin
        if (diff_ab) cnt_ab <= sat_inc(cnt_ab);
        if (diff_bc) cnt_bc <= sat_inc(cnt_bc);
        if (diff_ac) cnt_ac <= sat_inc(cnt_ac);
        if ((diff_ab || diff_bc || diff_ac) && !first_vld) begin
          first_idx <= idx;
          first_vld <= 1'b1;
        end
        if (!last_sample) idx <= idx + WIN_ONE;
      end
    end
  end

`ifdef STORAGE_CMP_TOGGLE_CNT_EN
  logic prev_a, prev_b, prev_c;

  // Toggle counters. prev_* always holds last cycle's synchronised value, so
  // at the first MEASURE sample it carries the value seen in the last ARM
  // cycle: the comparison is against a real input, never reset/stale state.
  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      prev_a <= 1'b0;
      prev_b <= 1'b0;
      prev_c <= 1'b0;
      tog_a  <= '0;
      tog_b  <= '0;
      tog_c  <= '0;
    end else begin
      prev_a <= sa;
      prev_b <= sb;
      prev_c <= sc;
      if (accept) begin
        tog_a <= '0;
        tog_b <= '0;
        tog_c <= '0;
      end else if (state == S_MEASURE) begin
        if (sa != prev_a) tog_a <= sat_inc(tog_a);
        if (sb != prev_b) tog_b <= sat_inc(tog_b);
        if (sc != prev_c) tog_c <= sat_inc(tog_c);
      end
    end
  end
`endif

endmodule

// File: tb/tb_storage_compare_monitor.sv
// tb_storage_compare_monitor
// Directed bench for storage_compare_monitor with a window-level model: every
// posedge records the inputs; the expected outputs are derived from which
// captured inputs fall inside the window and plain counting/saturation.
// Honours STORAGE_CMP_TOGGLE_CNT_EN when the build defines it.
module tb_storage_compare_monitor;

  localparam int CNT_W = 4;
  localparam int WIN_W = 6;
  localparam int S     = 2;
  localparam int SAT   = (1 << CNT_W) - 1;
  localparam int HIST  = 8192;

  logic             clk = 1'b0;
  logic             rst_n;
  logic             qa, qb, qc, start;
  logic [WIN_W-1:0] window_len;
  logic             busy, done, first_vld;
  logic [CNT_W-1:0] cnt_ab, cnt_bc, cnt_ac;
  logic [WIN_W-1:0] first_idx;
`ifdef STORAGE_CMP_TOGGLE_CNT_EN
  logic [CNT_W-1:0] tog_a, tog_b, tog_c;
`endif

  int n_checks = 0;
  int n_fail   = 0;

  always #5 clk = ~clk;

  storage_compare_monitor #(
    .CNT_W      (CNT_W),
    .WIN_W      (WIN_W),
    .SYNC_STAGES(S)
  ) dut (
    .clk       (clk),
    .rst_n     (rst_n),
    .qa        (qa),
    .qb        (qb),
    .qc        (qc),
    .start     (start),
    .window_len(window_len),
    .busy      (busy),
    .done      (done),
    .cnt_ab    (cnt_ab),
    .cnt_bc    (cnt_bc),
    .cnt_ac    (cnt_ac),
    .first_idx (first_idx),
    .first_vld (first_vld)
`ifdef STORAGE_CMP_TOGGLE_CNT_EN
    ,
    .tog_a     (tog_a),
    .tog_b     (tog_b),
    .tog_c     (tog_c)
`endif
  );

  // ---------------- model: input history and run bookkeeping ----------------
  int cyc  = 0;   // number of posedges seen out of reset
  int acc  = 0;   // edge number at which the current run was accepted
  int nlen = 0;   // window length latched for the current run
  bit run  = 1'b0;
  bit ha [HIST];
  bit hb [HIST];
  bit hc [HIST];

  always @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      run <= 1'b0;
    end else begin
      cyc <= cyc + 1;
      if (cyc + 1 < HIST) begin
        ha[cyc+1] <= qa;
        hb[cyc+1] <= qb;
        hc[cyc+1] <= qc;
      end
      // A run is finished once S+N edges have passed since its accept edge.
      if (start && (!run || (cyc - acc) >= S + nlen)) begin
        run  <= 1'b1;
        acc  <= cyc + 1;
        nlen <= int'(window_len);
      end
    end
  end

  typedef struct {
    int busy; int done; int ab; int bc; int ac; int fi; int fv;
    int ta; int tb; int tc;
  } exp_t;

  function automatic int sat(input int v);
    return (v > SAT) ? SAT : v;
  endfunction

  // Window sample j sees the inputs captured at edge acc+1+j; after el edges
  // since accept, el-S samples (clamped to 0..N) have been taken.
  function automatic exp_t model_now();
    exp_t e;
    int   el, m, p;
    e = '{default: 0};
    if (!run) return e;
    el     = cyc - acc;
    e.busy = (el < S + nlen) ? 1 : 0;
    e.done = 1 - e.busy;
    m = el - S;
    if (m < 0) m = 0;
    if (m > nlen) m = nlen;
    for (int j = 0; j < m; j++) begin
      p = acc + 1 + j;
      if (p >= HIST) break;
      if (ha[p] != hb[p]) e.ab++;
      if (hb[p] != hc[p]) e.bc++;
      if (ha[p] != hc[p]) e.ac++;
      if (e.fv == 0 && (ha[p] != hb[p] || hb[p] != hc[p])) begin
        e.fv = 1;
        e.fi = j;
      end
      if (ha[p] != ha[p-1]) e.ta++;
      if (hb[p] != hb[p-1]) e.tb++;
      if (hc[p] != hc[p-1]) e.tc++;
    end
    e.ab = sat(e.ab); e.bc = sat(e.bc); e.ac = sat(e.ac);
    e.ta = sat(e.ta); e.tb = sat(e.tb); e.tc = sat(e.tc);
    return e;
  endfunction

  // ---------------- checking ----------------
  task automatic check(input string name, input logic [31:0] act, input int exp);
    n_checks++;
    if (act !== 32'(exp)) begin
      n_fail++;
      $display("FAIL %s: actual %0d required %0d (edge %0d)", name, act, exp, cyc);
    end
  endtask

  task automatic compare_model();
    exp_t e;
    e = model_now();
    check("busy",      32'(busy),      e.busy);
    check("done",      32'(done),      e.done);
    check("cnt_ab",    32'(cnt_ab),    e.ab);
    check("cnt_bc",    32'(cnt_bc),    e.bc);
    check("cnt_ac",    32'(cnt_ac),    e.ac);
    check("first_idx", 32'(first_idx), e.fi);
    check("first_vld", 32'(first_vld), e.fv);
`ifdef STORAGE_CMP_TOGGLE_CNT_EN
    check("tog_a", 32'(tog_a), e.ta);
    check("tog_b", 32'(tog_b), e.tb);
    check("tog_c", 32'(tog_c), e.tc);
`endif
  endtask

  // One cycle: move to the falling edge and compare every output there.
  task automatic step();
    @(negedge clk);
    compare_model();
  endtask

  // Drives inputs for window index j (j=-1 is the capture at the accept edge).
  task automatic apply(input int mode, input int j);
    case (mode)
      0:       {qa, qb, qc} = 3'b111;
      1:       {qa, qb, qc} = 3'b110;
      2:       {qa, qb, qc} = 3'b101;
      3:       {qa, qb, qc} = {((j & 1) != 0), 2'b00};
      4:       {qa, qb, qc} = 3'($urandom);
      default: {qa, qb, qc} = (j == 62) ? 3'b001 : 3'b000;
    endcase
  endtask

  // Accepts one run of length n and returns edges from accept to done=1.
  // poke >= 0 raises start during the run at that cycle to test it is ignored.
  task automatic run_window(input int n, input int mode, input int poke, output int lat);
    step();
    window_len = WIN_W'(n);
    start      = 1'b1;
    apply(mode, -1);
    step();                          // accept edge has passed
    start      = 1'b0;
    window_len = WIN_W'($urandom);   // must be ignored while busy
    lat        = 0;
    apply(mode, 0);
    while (!done && lat < 300) begin
      start = (lat == poke);
      step();
      lat++;
      apply(mode, lat);
    end
    start = 1'b0;
    check("done_reached", 32'(done), 1);
  endtask

  int lat;

  initial begin
    rst_n = 1'b0; start = 1'b0; qa = 1'b0; qb = 1'b0; qc = 1'b0;
    window_len = '0;
    repeat (3) step();
    #2 rst_n = 1'b1;
    step();
    check("reset_busy",  32'(busy),      0);
    check("reset_done",  32'(done),      0);
    check("reset_fv",    32'(first_vld), 0);
    check("reset_cntbc", 32'(cnt_bc),    0);

    // All inputs equal: no mismatches.
    run_window(10, 0, -1, lat);
    check("t1_latency", 32'(lat), 12);
    check("t1_cnt_ab",  32'(cnt_ab), 0);
    check("t1_cnt_bc",  32'(cnt_bc), 0);
    check("t1_cnt_ac",  32'(cnt_ac), 0);
    check("t1_fv",      32'(first_vld), 0);

    // qc differs from qa/qb throughout (restart from DONE).
    run_window(8, 1, -1, lat);
    check("t2_latency", 32'(lat), 10);
    check("t2_cnt_ab",  32'(cnt_ab), 0);
    check("t2_cnt_bc",  32'(cnt_bc), 8);
    check("t2_cnt_ac",  32'(cnt_ac), 8);
    check("t2_fi",      32'(first_idx), 0);
    check("t2_fv",      32'(first_vld), 1);

    // Zero-length window goes straight to DONE after the flush.
    run_window(0, 1, -1, lat);
    check("t3_latency", 32'(lat), 2);
    check("t3_cnt_bc",  32'(cnt_bc), 0);
    check("t3_fv",      32'(first_vld), 0);

    // Saturation, then a clean rerun clears the counters.
    run_window(40, 2, -1, lat);
    check("t4_latency", 32'(lat), 42);
    check("t4_cnt_ab",  32'(cnt_ab), 15);
    check("t4_cnt_bc",  32'(cnt_bc), 15);
    check("t4_cnt_ac",  32'(cnt_ac), 0);
    run_window(5, 0, -1, lat);
    check("t4b_cnt_ab", 32'(cnt_ab), 0);

    // Reset at window index 5 of a 20-cycle run.
    step();
    window_len = WIN_W'(20);
    start = 1'b1;
    apply(1, -1);
    step();
    start = 1'b0;
    apply(1, 0);
    for (int j = 1; j <= S + 6; j++) begin
      step();
      apply(1, j);
    end
    check("t5_pre_busy",   32'(busy),   1);
    check("t5_pre_cnt_bc", 32'(cnt_bc), 6);
    #2 rst_n = 1'b0;
    #1;
    check("t5_rst_busy",   32'(busy),      0);
    check("t5_rst_done",   32'(done),      0);
    check("t5_rst_cnt_bc", 32'(cnt_bc),    0);
    check("t5_rst_cnt_ac", 32'(cnt_ac),    0);
    check("t5_rst_fv",     32'(first_vld), 0);
    step();
    step();
    #2 rst_n = 1'b1;

    // start raised mid-run and on the last sample edge must be ignored.
    run_window(10, 1, 4, lat);
    check("t6_latency", 32'(lat), 12);
    check("t6_cnt_bc",  32'(cnt_bc), 10);
    run_window(10, 1, 11, lat);
    check("t6b_latency", 32'(lat), 12);

    // Maximum window, single mismatch at the final index.
    run_window(63, 5, -1, lat);
    check("t7_latency", 32'(lat), 65);
    check("t7_fi",      32'(first_idx), 62);
    check("t7_fv",      32'(first_vld), 1);
    check("t7_cnt_bc",  32'(cnt_bc), 1);
    check("t7_cnt_ab",  32'(cnt_ab), 0);

    // Random inputs, model-checked every cycle.
    run_window(13, 4, -1, lat);
    check("t8_latency", 32'(lat), 15);

    // qa toggles every cycle; qb/qc constant.
    run_window(6, 3, -1, lat);
    check("t9_latency", 32'(lat), 8);
`ifdef STORAGE_CMP_TOGGLE_CNT_EN
    check("t9_tog_a", 32'(tog_a), 6);
    check("t9_tog_b", 32'(tog_b), 0);
    check("t9_tog_c", 32'(tog_c), 0);
`endif

    repeat (3) step();
    $display("End of test - %0d assertions evaluated, %0d failures", n_checks, n_fail);
    $finish;
  end

  initial begin
    #200000;
    $display("FAIL watchdog: simulation did not finish, actual timeout required completion");
    $fatal(1);
  end

endmodule
